// File: rtl/fft_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fft_sched_pkg
// Purpose : Shared types and helpers for the FFT frame scheduler.
//           t_sched_state - scheduler FSM state (IDLE / STREAM)
//           t_src_id      - source ID carried with each frame (1 bit)
//           frame_len()   - samples per frame for a given log2 length
// Revision: 1.0 - initial release
// ============================================================================
package fft_sched_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } t_sched_state;

    typedef logic t_src_id;

    function automatic int unsigned frame_len(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fft_tag_fifo
// Purpose : Synchronous FIFO of source IDs for frames in flight through the
//           FFT pipeline. Asynchronous active-high reset empties it.
// Ports   : clk, rst          - clock / async reset
//           push, din         - write din when push (a simultaneous pop
//                               frees a slot, so push while full is accepted
//                               only together with pop)
//           pop               - discard head (ignored when empty)
//           head              - oldest entry
//           full, empty       - occupancy flags
// Revision: 1.0 - initial release
// ============================================================================
module fft_tag_fifo
    import fft_sched_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  t_src_id din,
    input  logic    pop,
    output t_src_id head,
    output logic    full,
    output logic    empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    t_src_id       mem_q [DEPTH];
    t_src_id       mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    // Pointer wrap works for non-power-of-two depths too.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rd_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = ptr_inc(wr_q);
        end
        if (do_pop) begin
            rd_d = ptr_inc(rd_q);
        end
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_frame_sched.sv
`default_nettype none
// ============================================================================
// Module  : fft_frame_sched
// Purpose : Shares one radix-2 SDF FFT between two sample sources at frame
//           granularity (2^N samples). Issues start_ip / input mux select,
//           and tags each output frame with the source that supplied it.
// Ports   : clk, rst   - clock / asynchronous active-high reset
//           req[1:0]   - per-source "frame ready" level
//           gnt[1:0]   - one-hot grant, 2^N cycles per frame
//           smp_sel    - FFT input mux select (granted source)
//           start_ip   - pulse on first granted cycle of a frame
//           busy       - streaming or frames in flight
//           op_valid   - high for the 2^N output cycles of a frame
//           op_first   - pulse on first output sample of a frame
//           op_tag     - source ID of the frame at the output
// Config  : FFT_SCHED_ROUND_ROBIN_EN - round-robin arbitration when defined,
//           fixed priority (source 0 wins) otherwise.
// Revision: 1.0 - initial release
// ============================================================================
module fft_frame_sched
    import fft_sched_pkg::*;
#(
    parameter int N         = 3,
    parameter int LAT       = 8,
    parameter int TAG_DEPTH = 4
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       smp_sel,
    output logic       start_ip,
    output logic       busy,
    output logic       op_valid,
    output logic       op_first,
    output logic       op_tag
);

    localparam int unsigned    FRAME_LEN = frame_len(N);
    localparam logic [N-1:0]   LAST_CNT  = N'(FRAME_LEN - 1);

    t_sched_state    state_q, state_d;
    logic [N-1:0]    cnt_q, cnt_d;
    logic [1:0]      gnt_q, gnt_d;
    t_src_id         sel_q, sel_d;
    logic            start_q, start_d;
    logic [LAT-1:0]  dly_q, dly_d;
    logic [N-1:0]    ocnt_q, ocnt_d;
    t_src_id         tag_q, tag_d;

    t_src_id         fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    t_src_id         winner;
    logic            frame_end;
    logic            grant;

    // Decision points: any IDLE cycle, or the last sample of the current
    // frame (back-to-back). The current frame's tag is already in the FIFO
    // by then, so fifo_full accounts for it.
    assign frame_end = (state_q == STREAM) && (cnt_q == LAST_CNT);
    assign grant     = (req != 2'b00) && !fifo_full &&
                       ((state_q == IDLE) || frame_end);

`ifdef FFT_SCHED_ROUND_ROBIN_EN
    t_src_id last_q, last_d;

    always_comb begin
        if (req == 2'b11) begin
            winner = ~last_q;
        end else begin
            winner = req[1];
        end
        last_d = grant ? winner : last_q;
    end

    // Pointer resets to source 1 so source 0 wins the first contest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign winner = t_src_id'(~req[0]);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        start_d = 1'b0;
        if (state_q == STREAM) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (grant) begin
            state_d = STREAM;
            cnt_d   = '0;
            gnt_d   = winner ? 2'b10 : 2'b01;
            sel_d   = winner;
            start_d = 1'b1;
        end else if (frame_end) begin
            state_d = IDLE;
            cnt_d   = '0;
            gnt_d   = 2'b00;
        end
    end

    // start_ip travels LAT stages; the emerging pulse marks the first output
    // sample. The output counter then holds op_valid for the rest of the
    // frame, and wraps to 0 exactly when a back-to-back op_first reloads it.
    always_comb begin
        dly_d  = LAT'({dly_q, start_q});
        ocnt_d = ocnt_q;
        tag_d  = tag_q;
        if (op_first) begin
            ocnt_d = N'(1);
            tag_d  = fifo_head;
        end else if (ocnt_q != '0) begin
            ocnt_d = ocnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            start_q <= 1'b0;
            dly_q   <= '0;
            ocnt_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            start_q <= start_d;
            dly_q   <= dly_d;
            ocnt_q  <= ocnt_d;
            tag_q   <= tag_d;
        end
    end

    fft_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (start_q),
        .din   (sel_q),
        .pop   (op_first),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign gnt      = gnt_q;
    assign smp_sel  = sel_q;
    assign start_ip = start_q;
    assign op_first = dly_q[LAT-1];
    assign op_valid = op_first | (ocnt_q != '0);
    // Head is shown directly on op_first so the tag is valid from the first
    // output sample; the register holds it for the remainder of the frame.
    assign op_tag   = op_first ? fifo_head : tag_q;
    assign busy     = (state_q == STREAM) | ~fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_fft_frame_sched
// Purpose : Self-checking bench for fft_frame_sched. Two instances share the
//           stimulus: default parameters (N=3, LAT=8, TAG_DEPTH=4) and a
//           long-latency one (LAT=40, TAG_DEPTH=2). A frame-list reference
//           model predicts every output each cycle.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fft_frame_sched;

    localparam int FL   = 8;
    localparam int LAT0 = 8;
    localparam int DEP0 = 4;
    localparam int LAT1 = 40;
    localparam int DEP1 = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;

    logic [1:0] gnt0, gnt1;
    logic       sel0, sel1, st0, st1, bz0, bz1, ov0, ov1, of0, of1, tg0, tg1;

    fft_frame_sched #(.N(3), .LAT(LAT0), .TAG_DEPTH(DEP0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt0), .smp_sel(sel0),
        .start_ip(st0), .busy(bz0), .op_valid(ov0), .op_first(of0), .op_tag(tg0)
    );

    fft_frame_sched #(.N(3), .LAT(LAT1), .TAG_DEPTH(DEP1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt1), .smp_sel(sel1),
        .start_ip(st1), .busy(bz1), .op_valid(ov1), .op_first(of1), .op_tag(tg1)
    );

    always #5 clk = ~clk;

    // Reference model: list of granted frames (instance, start cycle, source)
    typedef struct {
        int inst;
        int start;
        bit src;
    } frame_t;

    typedef struct {
        logic [1:0] req;
        logic [1:0] gnt;
        logic       start;
        logic       opv;
        logic       opf;
        logic       busy;
    } vec_t;

    frame_t frames[$];
    bit     last_src[2];
    vec_t   tbl[18];
    int     t;
    int     checks;
    int     failures;

    task automatic chk(input string name, input int k, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d t=%0d actual=%0h required=%0h",
                     name, k, t, act, exp);
        end
    endtask

    task automatic obs(input int k, output logic [1:0] g, output logic s,
                       output logic st, output logic bz, output logic ov,
                       output logic of, output logic tg);
        if (k == 0) begin
            g = gnt0; s = sel0; st = st0; bz = bz0; ov = ov0; of = of0; tg = tg0;
        end else begin
            g = gnt1; s = sel1; st = st1; bz = bz1; ov = ov1; of = of1; tg = tg1;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int lat;
            logic [1:0] eg;
            logic esel, es, eov, eof, etag, eb;
            logic [1:0] g;
            logic s, st, bz, ov, of, tg;
            lat = (k == 0) ? LAT0 : LAT1;
            eg = 2'b00; esel = 0; es = 0; eov = 0; eof = 0; etag = 0; eb = 0;
            foreach (frames[i]) begin
                if (frames[i].inst == k) begin
                    int s0;
                    s0 = frames[i].start;
                    if (t >= s0 && t < s0 + FL) begin
                        eg   = frames[i].src ? 2'b10 : 2'b01;
                        esel = frames[i].src;
                    end
                    if (t == s0) es = 1;
                    if (t >= s0 + lat && t < s0 + lat + FL) begin
                        eov  = 1;
                        etag = frames[i].src;
                    end
                    if (t == s0 + lat) eof = 1;
                    // streaming s0..s0+FL-1, tag queued s0+1..s0+lat
                    if (t >= s0 && (t < s0 + FL || t <= s0 + lat)) eb = 1;
                end
            end
            obs(k, g, s, st, bz, ov, of, tg);
            chk("gnt", k, {6'd0, g}, {6'd0, eg});
            if (eg != 2'b00) chk("smp_sel", k, {7'd0, s}, {7'd0, esel});
            chk("start_ip", k, {7'd0, st}, {7'd0, es});
            chk("busy", k, {7'd0, bz}, {7'd0, eb});
            chk("op_valid", k, {7'd0, ov}, {7'd0, eov});
            chk("op_first", k, {7'd0, of}, {7'd0, eof});
            if (eov) chk("op_tag", k, {7'd0, tg}, {7'd0, etag});
        end
    endtask

    task automatic decide(input int k, input logic [1:0] r);
        int lat, dep, inflight;
        bit free;
        bit w;
        lat = (k == 0) ? LAT0 : LAT1;
        dep = (k == 0) ? DEP0 : DEP1;
        free = 1;
        inflight = 0;
        foreach (frames[i]) begin
            if (frames[i].inst == k) begin
                int s0;
                s0 = frames[i].start;
                if (t >= s0 && t < s0 + FL - 1) free = 0;
                if (s0 < t && t <= s0 + lat) inflight++;
            end
        end
        if (free && r != 2'b00 && inflight < dep) begin
`ifdef FFT_SCHED_ROUND_ROBIN_EN
            w = (r == 2'b11) ? !last_src[k] : r[1];
`else
            w = !r[0];
`endif
            last_src[k] = w;
            frames.push_back('{inst: k, start: t + 1, src: w});
        end
    endtask

    task automatic step(input logic [1:0] r);
        check_all();
        req = r;
        decide(0, r);
        decide(1, r);
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic reset_dut();
        logic [1:0] g;
        logic s, st, bz, ov, of, tg;
        rst = 1'b1;
        req = 2'b00;
        #1;
        for (int k = 0; k < 2; k++) begin
            obs(k, g, s, st, bz, ov, of, tg);
            chk("reset_outputs", k, {g, s, st, bz, ov, of, tg}, 8'h00);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        frames.delete();
        last_src[0] = 1'b1;
        last_src[1] = 1'b1;
        t = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        logic [1:0] g;
        logic s, st, bz, ov, of, tg;
        int n_src1;
        checks   = 0;
        failures = 0;
        t        = 0;

        // Single frame from source 0, request dropped right after the grant
        for (int i = 0; i < 18; i++) begin
            tbl[i].req   = (i == 0) ? 2'b01 : 2'b00;
            tbl[i].gnt   = (i >= 1 && i <= 8) ? 2'b01 : 2'b00;
            tbl[i].start = (i == 1);
            tbl[i].opv   = (i >= 9 && i <= 16);
            tbl[i].opf   = (i == 9);
            tbl[i].busy  = (i >= 1 && i <= 9);
        end

        rst = 1'b1;
        repeat (2) @(posedge clk);
        reset_dut();

        for (int i = 0; i < 18; i++) begin
            obs(0, g, s, st, bz, ov, of, tg);
            chk("tbl_gnt", 0, {6'd0, g}, {6'd0, tbl[i].gnt});
            chk("tbl_start", 0, {7'd0, st}, {7'd0, tbl[i].start});
            chk("tbl_op_valid", 0, {7'd0, ov}, {7'd0, tbl[i].opv});
            chk("tbl_op_first", 0, {7'd0, of}, {7'd0, tbl[i].opf});
            chk("tbl_busy", 0, {7'd0, bz}, {7'd0, tbl[i].busy});
            step(tbl[i].req);
        end

        // Both sources requesting continuously
        repeat (5) step(2'b00);
        n_src1 = 0;
        for (int i = 0; i < 48; i++) begin
            if (st0 && sel0) n_src1++;
            step(2'b11);
        end
`ifdef FFT_SCHED_ROUND_ROBIN_EN
        chk("rr_src1_served", 0, {7'd0, n_src1 >= 2}, 8'd1);
`else
        chk("fixed_src1_starved", 0, n_src1[7:0], 8'd0);
`endif
        repeat (60) step(2'b00);

        // Request dropped at sample 3: frame still completes
        repeat (4) step(2'b01);
        repeat (60) step(2'b00);

        // Held request: long-latency instance stalls on a full tag FIFO
        repeat (120) step(2'b01);
        repeat (60) step(2'b00);

        // Randomized request patterns with varying densities
        for (int b = 0; b < 12; b++) begin
            int p0, p1;
            p0 = $urandom_range(0, 100);
            p1 = $urandom_range(0, 100);
            for (int i = 0; i < 50; i++) begin
                logic [1:0] r;
                r[0] = ($urandom_range(0, 99) < p0);
                r[1] = ($urandom_range(0, 99) < p1);
                step(r);
            end
        end
        repeat (60) step(2'b00);

        // Reset at sample 5 of the second back-to-back frame
        repeat (14) step(2'b11);
        check_all();
        reset_dut();
        repeat (60) step(2'b00);
        step(2'b11);
        obs(0, g, s, st, bz, ov, of, tg);
        chk("post_reset_first_gnt", 0, {6'd0, g}, 8'h01);
        obs(1, g, s, st, bz, ov, of, tg);
        chk("post_reset_first_gnt", 1, {6'd0, g}, 8'h01);
        repeat (10) step(2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
